bsg_circular_ptr_retx: RTL and testbench
========================================

Name: bsg_circular_ptr_retx

Overview:
- Successor to the single circular pointer: tracks one circular buffer of els_p slots (any els_p ≥ 1, not just powers of two) with three coupled pointers:
  - write (wptr): advanced by enqueue.
  - speculative read (rptr): advanced by dequeue.
  - committed read (cptr): advanced by commit.
- Rewind returns rptr to cptr for retransmission.
- Sits beside a 1R1W buffer in link/retransmit FIFOs; the buffer storage lives outside this block.
- Provides occupancy and free-space accounting and illegal-request detection.

Parameters:
- els_p, -1, number of slots; must be ≥ 1.
- max_enq_p, -1, maximum entries enqueued per cycle; ≥ 1.
- max_deq_p, -1, maximum entries dequeued or committed per cycle; ≥ 1.
- ptr_width_lp (local), `BSG_SAFE_CLOG2(els_p), pointer width.
- cnt_width_lp (local), $clog2(els_p+1), count width.

Ports:
- clk  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- enq_i  in  $clog2(max_enq_p+1)  entries written this cycle.
- deq_i  in  $clog2(max_deq_p+1)  entries speculatively read this cycle.
- commit_i  in  $clog2(max_deq_p+1)  entries retired (space freed) this cycle.
- rewind_i  in  1  reset rptr to cptr.
- wptr_o  out  ptr_width_lp  write pointer.
- rptr_o  out  ptr_width_lp  speculative read pointer.
- cptr_o  out  ptr_width_lp  committed read pointer.
- readable_o  out  cnt_width_lp  entries between rptr and wptr.
- inflight_o  out  cnt_width_lp  entries between cptr and rptr.
- free_o  out  cnt_width_lp  els_p − readable − inflight.
- full_o  out  1  free_o == 0.
- empty_o  out  1  readable_o == 0.
- err_o  out  1  sticky illegal-request flag.

Behaviour:
- All outputs come straight from registers or are decoded from registers. An update in cycle N is visible in cycle N+1.
- Reset values:
  - wptr_o = rptr_o = cptr_o = 0
  - readable_o = 0, inflight_o = 0, free_o = els_p
  - full_o = 0, empty_o = 1, err_o = 0
- reset_i mid-operation discards all state in the same edge and ignores all other inputs that cycle.
- Legality is checked against registered values only:
  - enq legal iff enq_i ≤ free_r.
  - deq legal iff deq_i ≤ readable_r.
  - commit legal iff commit_i ≤ inflight_r.
- An illegal operation is dropped: its pointer and counts do not move. err_o is set on the next edge and holds until reset. Other legal operations in the same cycle still execute. Simulation-only assertion fires with the offending values.
- Pointer advance is modular: p_n = (p + n ≥ els_p) ? p + n − els_p : p + n. It is computed at ptr_width_lp+1 bits so no intermediate overflow occurs.
- For els_p == 1 all pointers are constant 0. Counts still operate in the range 0..1.
- Count updates with no rewind:
  - readable_n = readable + enq − deq
  - inflight_n = inflight + deq − commit
  - free_n = free + commit − enq
  - Each term is included only if its operation is legal.
- rewind_i:
  - rptr_n = cptr_n, i.e. the post-commit cptr.
  - readable_n = readable + inflight − commit + enq.
  - inflight_n = 0.
  - deq_i is ignored that cycle; it is not an error even if nonzero.
- Simultaneous enq and commit: a slot freed by commit in cycle N is not usable by enq until N+1, because the free check uses the registered value.
- Full wrap case: wptr == cptr with free == 0 means full. wptr == cptr with free == els_p means empty-of-all. Pointer equality is never used alone to decide full or empty.
- Invariant, checked by assertion every cycle: readable + inflight + free == els_p.

Decomposition:
- No new package. Widths come from `BSG_SAFE_CLOG2 and $clog2 in bsg_defines.
- One sub-module, bsg_mod_add: combinational modular adder.
  - Parameters: els_p, max_add_p.
  - Ports: ptr_i, add_i, ptr_o.
  - Instantiated three times, for wptr, rptr and cptr.
- The rewind mux and count arithmetic stay in the top module.

Test Plan (els_p=5, max_enq_p=3, max_deq_p=2):
- Reset, then enq_i=3, then enq_i=2 → wptr_o 3 then 0 (wrap), readable_o 5, free_o 0, full_o=1, err_o=0.
- From full: deq_i=2, deq_i=2, then commit_i=2 → rptr_o 2 then 4, inflight_o 4 then 2, free_o 0 then 2, cptr_o 2.
- From the previous state, rewind_i=1 with deq_i=2 and commit_i=1 → cptr_o 3, rptr_o 3, inflight_o 0, readable_o 2, free_o 3; deq ignored, err_o=0.
- Empty buffer, deq_i=1 with enq_i=2 → deq dropped, enq applied: readable_o 2, err_o=1 and stays 1 until reset_i.
- With free_o=0, commit_i=2 and enq_i=2 in the same cycle → enq dropped, err_o=1, free_o 2 the next cycle; enq_i=2 in the following cycle succeeds.
- Run 1000 random legal ops, with reset_i asserted mid-stream → invariant holds every cycle and all outputs return to reset values one edge after reset_i.
- Run the random test with els_p=1 and with els_p=8 → same invariant holds.

Source files
------------

// File: rtl/bsg_mod_add.sv
// ============================================================================
//  Module      : bsg_mod_add
//  Description : Combinational modular adder; wraps ptr_i + add_i at els_p.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bsg_mod_add #(
    parameter int els_p     = -1,
    parameter int max_add_p = -1,
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int add_width_lp = (max_add_p >= 1) ? $clog2(max_add_p + 1) : 1
) (
    input  logic [ptr_width_lp-1:0] ptr_i,
    input  logic [add_width_lp-1:0] add_i,
    output logic [ptr_width_lp-1:0] ptr_o
);

    generate
        if (els_p <= 1) begin : g_single
            logic w_unused;
            assign w_unused = ^{ptr_i, add_i};
            assign ptr_o    = '0;
        end else begin : g_mod
            // One bit of headroom so ptr + add cannot overflow before the wrap test
            localparam int sum_width_lp =
                ((ptr_width_lp > add_width_lp) ? ptr_width_lp : add_width_lp) + 1;
            logic [sum_width_lp-1:0] w_sum;
            logic [sum_width_lp-1:0] w_els;
            assign w_sum = sum_width_lp'(ptr_i) + sum_width_lp'(add_i);
            assign w_els = sum_width_lp'(els_p);
            assign ptr_o = (w_sum >= w_els) ? ptr_width_lp'(w_sum - w_els)
                                            : ptr_width_lp'(w_sum);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bsg_circular_ptr_retx.sv
// ============================================================================
//  Module      : bsg_circular_ptr_retx
//  Description : Write / speculative-read / committed-read pointers with rewind.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bsg_circular_ptr_retx #(
    parameter int els_p     = -1,
    parameter int max_enq_p = -1,
    parameter int max_deq_p = -1,
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp = (els_p >= 1) ? $clog2(els_p + 1) : 1,
    localparam int enq_width_lp = (max_enq_p >= 1) ? $clog2(max_enq_p + 1) : 1,
    localparam int deq_width_lp = (max_deq_p >= 1) ? $clog2(max_deq_p + 1) : 1
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [enq_width_lp-1:0] enq_i,
    input  logic [deq_width_lp-1:0] deq_i,
    input  logic [deq_width_lp-1:0] commit_i,
    input  logic                    rewind_i,
    output logic [ptr_width_lp-1:0] wptr_o,
    output logic [ptr_width_lp-1:0] rptr_o,
    output logic [ptr_width_lp-1:0] cptr_o,
    output logic [cnt_width_lp-1:0] readable_o,
    output logic [cnt_width_lp-1:0] inflight_o,
    output logic [cnt_width_lp-1:0] free_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    err_o
);

    localparam int wide_a_lp = (cnt_width_lp > enq_width_lp) ? cnt_width_lp : enq_width_lp;
    localparam int wide_lp   = ((wide_a_lp > deq_width_lp) ? wide_a_lp : deq_width_lp) + 2;

    logic [ptr_width_lp-1:0] wptr_q, rptr_q, cptr_q;
    logic [ptr_width_lp-1:0] wptr_d, rptr_d, cptr_d;
    logic [cnt_width_lp-1:0] readable_q, inflight_q, free_q;
    logic [cnt_width_lp-1:0] readable_d, inflight_d, free_d;
    logic                    err_q, err_d;

    logic [wide_lp-1:0] w_enq, w_deq, w_cm, w_rd, w_inf, w_free;
    logic [wide_lp-1:0] w_enq_add, w_deq_add, w_cm_add;
    logic [enq_width_lp-1:0] w_enq_eff;
    logic [deq_width_lp-1:0] w_deq_eff, w_cm_eff;
    logic [ptr_width_lp-1:0] w_rptr_adv;
    logic w_enq_ok, w_deq_ok, w_cm_ok;

    assign w_enq  = wide_lp'(enq_i);
    assign w_deq  = wide_lp'(deq_i);
    assign w_cm   = wide_lp'(commit_i);
    assign w_rd   = wide_lp'(readable_q);
    assign w_inf  = wide_lp'(inflight_q);
    assign w_free = wide_lp'(free_q);

    // Legality uses registered counts only; a slot freed this cycle is not yet usable
    assign w_enq_ok = (w_enq <= w_free);
    assign w_deq_ok = rewind_i || (w_deq <= w_rd);
    assign w_cm_ok  = (w_cm <= w_inf);

    assign w_enq_eff = w_enq_ok ? enq_i : '0;
    assign w_deq_eff = (w_deq_ok && !rewind_i) ? deq_i : '0;
    assign w_cm_eff  = w_cm_ok ? commit_i : '0;
    assign w_enq_add = wide_lp'(w_enq_eff);
    assign w_deq_add = wide_lp'(w_deq_eff);
    assign w_cm_add  = wide_lp'(w_cm_eff);

    bsg_mod_add #(.els_p(els_p), .max_add_p(max_enq_p)) u_wptr_add (
        .ptr_i (wptr_q),
        .add_i (w_enq_eff),
        .ptr_o (wptr_d)
    );

    bsg_mod_add #(.els_p(els_p), .max_add_p(max_deq_p)) u_rptr_add (
        .ptr_i (rptr_q),
        .add_i (w_deq_eff),
        .ptr_o (w_rptr_adv)
    );

    bsg_mod_add #(.els_p(els_p), .max_add_p(max_deq_p)) u_cptr_add (
        .ptr_i (cptr_q),
        .add_i (w_cm_eff),
        .ptr_o (cptr_d)
    );

    // Rewind lands on the post-commit cptr, so everything after it becomes readable again
    assign rptr_d     = rewind_i ? cptr_d : w_rptr_adv;
    assign readable_d = rewind_i ? cnt_width_lp'(w_rd + w_inf - w_cm_add + w_enq_add)
                                 : cnt_width_lp'(w_rd + w_enq_add - w_deq_add);
    assign inflight_d = rewind_i ? '0 : cnt_width_lp'(w_inf + w_deq_add - w_cm_add);
    assign free_d     = cnt_width_lp'(w_free + w_cm_add - w_enq_add);
    assign err_d      = err_q || !w_enq_ok || !w_deq_ok || !w_cm_ok;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cptr_q     <= '0;
            readable_q <= '0;
            inflight_q <= '0;
            free_q     <= cnt_width_lp'(els_p);
            err_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cptr_q     <= cptr_d;
            readable_q <= readable_d;
            inflight_q <= inflight_d;
            free_q     <= free_d;
            err_q      <= err_d;
        end
    end

    always @(posedge clk) begin
        if (!reset_i) begin
            assert (w_enq_ok) else $warning("illegal enq %0d > free %0d", enq_i, free_q);
            assert (w_deq_ok) else $warning("illegal deq %0d > readable %0d", deq_i, readable_q);
            assert (w_cm_ok)  else $warning("illegal commit %0d > inflight %0d", commit_i, inflight_q);
            assert (w_rd + w_inf + w_free == wide_lp'(els_p))
                else $error("count invariant broken: %0d+%0d+%0d", readable_q, inflight_q, free_q);
        end
    end

    assign wptr_o     = wptr_q;
    assign rptr_o     = rptr_q;
    assign cptr_o     = cptr_q;
    assign readable_o = readable_q;
    assign inflight_o = inflight_q;
    assign free_o     = free_q;
    assign full_o     = (free_q == '0);
    assign empty_o    = (readable_q == '0);
    assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_circular_ptr_retx.sv
// ============================================================================
//  Module      : tb_bsg_circular_ptr_retx
//  Description : Scoreboard bench for three instances (els_p = 5, 1, 8).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_circular_ptr_retx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] enq [3];
    logic [1:0] deq [3];
    logic [1:0] cm  [3];
    logic       rew [3];

    logic [2:0] w5, r5, c5, rd5, inf5, fr5;
    logic       full5, empty5, err5;
    logic [0:0] w1, r1, c1, rd1, inf1, fr1;
    logic       full1, empty1, err1;
    logic [2:0] w8, r8, c8;
    logic [3:0] rd8, inf8, fr8;
    logic       full8, empty8, err8;

    bsg_circular_ptr_retx #(.els_p(5), .max_enq_p(3), .max_deq_p(2)) u_dut5 (
        .clk(clk), .reset_i(reset), .enq_i(enq[0]), .deq_i(deq[0]), .commit_i(cm[0]),
        .rewind_i(rew[0]), .wptr_o(w5), .rptr_o(r5), .cptr_o(c5), .readable_o(rd5),
        .inflight_o(inf5), .free_o(fr5), .full_o(full5), .empty_o(empty5), .err_o(err5));

    bsg_circular_ptr_retx #(.els_p(1), .max_enq_p(3), .max_deq_p(2)) u_dut1 (
        .clk(clk), .reset_i(reset), .enq_i(enq[1]), .deq_i(deq[1]), .commit_i(cm[1]),
        .rewind_i(rew[1]), .wptr_o(w1), .rptr_o(r1), .cptr_o(c1), .readable_o(rd1),
        .inflight_o(inf1), .free_o(fr1), .full_o(full1), .empty_o(empty1), .err_o(err1));

    bsg_circular_ptr_retx #(.els_p(8), .max_enq_p(3), .max_deq_p(2)) u_dut8 (
        .clk(clk), .reset_i(reset), .enq_i(enq[2]), .deq_i(deq[2]), .commit_i(cm[2]),
        .rewind_i(rew[2]), .wptr_o(w8), .rptr_o(r8), .cptr_o(c8), .readable_o(rd8),
        .inflight_o(inf8), .free_o(fr8), .full_o(full8), .empty_o(empty8), .err_o(err8));

    typedef struct {
        int w, r, c, rd, inf, fr, err;
    } st_t;

    typedef struct {
        int  idx;
        st_t s;
    } exp_t;

    st_t  m [3];
    int   els [3] = '{5, 1, 8};
    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int mn(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic st_t step(st_t s, int n, int e, int d, int c, bit rw, bit rst);
        st_t o;
        bit eok, dok, cok;
        if (rst) begin
            o = '{0, 0, 0, 0, 0, n, 0};
            return o;
        end
        eok = (e <= s.fr);
        cok = (c <= s.inf);
        dok = rw || (d <= s.rd);
        if (!eok) e = 0;
        if (!cok) c = 0;
        if (!dok || rw) d = 0;
        o     = s;
        o.err = (s.err != 0 || !eok || !cok || !dok) ? 1 : 0;
        o.w   = (s.w + e) % n;
        o.c   = (s.c + c) % n;
        o.fr  = s.fr + c - e;
        if (rw) begin
            o.r   = o.c;
            o.rd  = s.rd + s.inf - c + e;
            o.inf = 0;
        end else begin
            o.r   = (s.r + d) % n;
            o.rd  = s.rd + e - d;
            o.inf = s.inf + d - c;
        end
        return o;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input int exp_v);
        n_cmp++;
        assert (obs === 32'(exp_v))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk(input int idx, input logic [31:0] w, r, c, rd, inf, fr,
                       input logic [31:0] full, empty, err);
        exp_t  e;
        string p;
        p = $sformatf("els%0d", els[idx]);
        if (sb.size() == 0) begin
            cmp({p, ".scoreboard_empty"}, 32'd1, 0);
            return;
        end
        e = sb.pop_front();
        cmp({p, ".idx"},      32'(e.idx), idx);
        cmp({p, ".wptr"},     w,     e.s.w);
        cmp({p, ".rptr"},     r,     e.s.r);
        cmp({p, ".cptr"},     c,     e.s.c);
        cmp({p, ".readable"}, rd,    e.s.rd);
        cmp({p, ".inflight"}, inf,   e.s.inf);
        cmp({p, ".free"},     fr,    e.s.fr);
        cmp({p, ".full"},     full,  (e.s.fr == 0) ? 1 : 0);
        cmp({p, ".empty"},    empty, (e.s.rd == 0) ? 1 : 0);
        cmp({p, ".err"},      err,   e.s.err);
    endtask

    // Push expectations for the current inputs, clock once, then compare all three.
    task automatic cycle();
        for (int i = 0; i < 3; i++) begin
            m[i] = step(m[i], els[i], int'(enq[i]), int'(deq[i]), int'(cm[i]), rew[i], reset);
            sb.push_back('{i, m[i]});
        end
        @(posedge clk);
        #1;
        chk(0, w5, r5, c5, rd5, inf5, fr5, full5, empty5, err5);
        chk(1, w1, r1, c1, rd1, inf1, fr1, full1, empty1, err1);
        chk(2, w8, r8, c8, rd8, inf8, fr8, full8, empty8, err8);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            enq[i] = '0; deq[i] = '0; cm[i] = '0; rew[i] = 1'b0;
        end
    endtask

    task automatic op5(input int e, input int d, input int c, input bit rw);
        idle_all();
        enq[0] = 2'(e); deq[0] = 2'(d); cm[0] = 2'(c); rew[0] = rw;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, els[i], 0};
        idle_all();
        reset = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        cmp("reset.free5", 32'(fr5), 5);
        cmp("reset.empty5", 32'(empty5), 1);
        reset = 1'b0;

        // Fill to full with a wrap of wptr
        op5(3, 0, 0, 0);
        cmp("fill.wptr3", 32'(w5), 3);
        op5(2, 0, 0, 0);
        cmp("wrap.wptr0", 32'(w5), 0);
        cmp("wrap.full", 32'(full5), 1);

        // Speculative reads then commit
        op5(0, 2, 0, 0);
        op5(0, 2, 0, 0);
        cmp("deq.rptr4", 32'(r5), 4);
        op5(0, 0, 2, 0);
        cmp("commit.free2", 32'(fr5), 2);

        // Rewind with concurrent commit; deq ignored
        op5(0, 2, 1, 1);
        cmp("rewind.rptr3", 32'(r5), 3);
        cmp("rewind.readable2", 32'(rd5), 2);
        cmp("rewind.err0", 32'(err5), 0);

        // Reset mid-operation with inputs active
        enq[0] = 2'd3; deq[0] = 2'd1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;

        // Illegal deq on empty; enq still applies
        op5(2, 1, 0, 0);
        cmp("illdeq.err", 32'(err5), 1);
        op5(3, 0, 0, 0);
        op5(0, 2, 0, 0);
        // free==0: enq dropped while commit frees two slots
        op5(2, 0, 2, 0);
        cmp("sameclk.free2", 32'(fr5), 2);
        op5(2, 0, 0, 0);
        cmp("nextclk.full", 32'(full5), 1);
        cmp("sticky.err", 32'(err5), 1);

        reset = 1'b1;
        idle_all();
        cycle();
        reset = 1'b0;

        // Random legal traffic on all three instances with a mid-stream reset
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < 3; i++) begin
                enq[i] = 2'($urandom_range(0, mn(3, m[i].fr)));
                deq[i] = 2'($urandom_range(0, mn(2, m[i].rd)));
                cm[i]  = 2'($urandom_range(0, mn(2, m[i].inf)));
                rew[i] = ($urandom_range(0, 9) == 0);
            end
            reset = (it == 500);
            cycle();
            if (it == 500) begin
                cmp("midrst.free8", 32'(fr8), 8);
                cmp("midrst.wptr5", 32'(w5), 0);
            end
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
